// File: rtl/dmi_req_adapter.sv
// Core-clock stage between the JTAG DMI wrapper and the debug module: turns access
// pulses into a held valid/ready request, tracks one transaction, flags overrun/timeout.
module dmi_req_adapter #(
  parameter int unsigned TIMEOUT_W  = 8,
  parameter bit          TIMEOUT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_en,
  input  logic        reg_wr_en,
  input  logic [6:0]  reg_wr_addr,
  input  logic [31:0] reg_wr_data,
  output logic        dmi_req_valid,
  output logic        dmi_req_write,
  output logic [6:0]  dmi_req_addr,
  output logic [31:0] dmi_req_wdata,
  input  logic        dmi_req_ready,
  input  logic        dmi_rsp_valid,
  input  logic [31:0] dmi_rsp_rdata,
  output logic        dmi_rsp_ready,
  output logic [31:0] rd_data,
  input  logic        dmi_reset,
  output logic        busy,
  output logic        done,
  output logic        err_overrun,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  state_e               state_r;
  state_e               state_nxt_s;
  logic [TIMEOUT_W-1:0] tmo_cnt_r;
  logic                 accept_s;
  logic                 req_hs_s;
  logic                 rsp_hs_s;
  logic                 abort_s;
  logic                 overrun_s;
  logic                 tmo_hit_s;

  assign busy          = (state_r != ST_IDLE);
  assign dmi_rsp_ready = (state_r == ST_RSP);
  assign overrun_s     = reg_en & busy;
  // A handshake in the terminal-count cycle wins over the abort.
  assign tmo_hit_s     = TIMEOUT_EN & (tmo_cnt_r == {TIMEOUT_W{1'b1}});

  // Next-state decode and per-cycle transaction events.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    req_hs_s    = 1'b0;
    rsp_hs_s    = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (reg_en) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmi_req_valid & dmi_req_ready) begin
          req_hs_s    = 1'b1;
          state_nxt_s = ST_RSP;
        end else if (tmo_hit_s) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RSP: begin
        if (dmi_rsp_valid) begin
          rsp_hs_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (tmo_hit_s) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RSP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request payload, valid, completion pulse, read data and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmi_req_valid <= 1'b0;
      dmi_req_write <= 1'b0;
      dmi_req_addr  <= 7'd0;
      dmi_req_wdata <= 32'd0;
      rd_data       <= 32'd0;
      done          <= 1'b0;
      tmo_cnt_r     <= {TIMEOUT_W{1'b0}};
    end else begin
      if (accept_s) begin
        dmi_req_write <= reg_wr_en;
        dmi_req_addr  <= reg_wr_addr;
        dmi_req_wdata <= reg_wr_data;
      end
      if (accept_s) begin
        dmi_req_valid <= 1'b1;
      end else if (req_hs_s | abort_s) begin
        dmi_req_valid <= 1'b0;
      end
      done <= rsp_hs_s;
      if (rsp_hs_s & ~dmi_req_write) begin
        rd_data <= dmi_rsp_rdata;
      end
      if (accept_s) begin
        tmo_cnt_r <= {TIMEOUT_W{1'b0}};
      end else if (busy) begin
        tmo_cnt_r <= tmo_cnt_r + TIMEOUT_W'(1);
      end
    end
  end

  // Sticky error flags; a set in the same cycle beats dmi_reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (overrun_s) begin
        err_overrun <= 1'b1;
      end else if (dmi_reset) begin
        err_overrun <= 1'b0;
      end
      if (abort_s) begin
        err_timeout <= 1'b1;
      end else if (dmi_reset) begin
        err_timeout <= 1'b0;
      end
    end
  end

endmodule
